// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clk out.
// A one-word hold register lets consecutive words stream with no idle gap between them.
module seq_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned      CntW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             out_q, out_d;
  logic             xfer;

  // Bit that leaves first from a word, and the word with that bit consumed.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_ready = ~hold_full_q;
  assign xfer       = load_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    out_d       = out_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          out_d   = head(data_in);
          shift_d = advance(data_in);
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          out_d = IDLE_BIT;
        end
      end
      StShift: begin
        if (cnt_q == LastCnt) begin
          // Hold has priority; a transfer cannot coincide since load_ready is low.
          if (hold_full_q) begin
            out_d       = head(hold_q);
            shift_d     = advance(hold_q);
            cnt_d       = '0;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            out_d   = head(data_in);
            shift_d = advance(data_in);
            cnt_d   = '0;
          end else begin
            out_d   = IDLE_BIT;
            state_d = StIdle;
          end
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          out_d   = head(shift_q);
          shift_d = advance(shift_q);
          if (xfer) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      out_q       <= IDLE_BIT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_q       <= out_d;
    end
  end

  assign out       = out_q;
  assign busy      = (state_q == StShift);
  assign word_done = (state_q == StShift) && (cnt_q == LastCnt);

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances on shared stimulus,
// checked every cycle against a word-queue reference model, plus directed scenarios.
module tb_seq_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready, out, busy, word_done;
  logic         lsb_ready, lsb_out, lsb_busy, lsb_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words accepted but not yet fully sent; wq[0] is on the wire.
  logic [W-1:0] wq[$];
  int           pos = 0;

  // Captured output history, newest bit in bit 0.
  logic [31:0] cap, cap_lsb;
  int          done_cnt, ready_low_cnt;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .out        (out),
    .busy       (busy),
    .word_done  (word_done)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (lsb_ready),
    .out        (lsb_out),
    .busy       (lsb_busy),
    .word_done  (lsb_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic msb_first);
    logic [W-1:0] w;
    if (wq.size() == 0) return 1'b0;
    w = wq[0];
    return msb_first ? w[W-1-pos] : w[pos];
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [W-1:0] d);
    logic acc;
    if (r) begin
      wq.delete();
      pos = 0;
    end else begin
      acc = v && (wq.size() < 2);
      if (wq.size() > 0) begin
        if (pos == W - 1) begin
          void'(wq.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (acc) wq.push_back(d);
    end
  endtask

  // Check the current cycle, then apply inputs for the coming edge and advance the model.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
    logic act;
    @(negedge clk);
    act = (wq.size() > 0);
    check("out_msb",    {31'd0, out},        {31'd0, exp_bit(1'b1)});
    check("out_lsb",    {31'd0, lsb_out},    {31'd0, exp_bit(1'b0)});
    check("busy",       {31'd0, busy},       {31'd0, act});
    check("word_done",  {31'd0, word_done},  {31'd0, act && (pos == W - 1)});
    check("lsb_done",   {31'd0, lsb_done},   {31'd0, act && (pos == W - 1)});
    check("load_ready", {31'd0, load_ready}, {31'd0, wq.size() < 2});
    cap     = {cap[30:0], out};
    cap_lsb = {cap_lsb[30:0], lsb_out};
    if (word_done) done_cnt++;
    if (!load_ready) ready_low_cnt++;
    rst        = r;
    load_valid = v;
    data_in    = d;
    @(posedge clk);
    model_edge(r, v, d);
  endtask

  task automatic clear_caps();
    cap           = '0;
    cap_lsb       = '0;
    done_cnt      = 0;
    ready_low_cnt = 0;
  endtask

  initial begin
    clear_caps();
    // Reset held for two edges with a word offered; nothing may be taken.
    rst        = 1'b1;
    load_valid = 1'b1;
    data_in    = 8'hFF;
    repeat (2) @(posedge clk);
    model_edge(1'b1, 1'b1, 8'hFF);
    @(negedge clk);
    check("rst_out",   {31'd0, out},        32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_done",  {31'd0, word_done},  32'd0);
    check("rst_ready", {31'd0, load_ready}, 32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Single word 0x53, MSB first.
    cycle(1'b0, 1'b1, 8'h53);
    clear_caps();
    repeat (8) cycle(1'b0, 1'b0, 8'h00);
    check("single_bits", {24'd0, cap[7:0]}, 32'h53);
    check("single_lsb",  {24'd0, cap_lsb[7:0]}, 32'hCA);
    check("single_done", done_cnt, 32'd1);
    check("single_last_done", {31'd0, word_done}, 32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    check("single_idle_out",  {31'd0, cap[0]}, 32'd0);
    check("single_idle_busy", {31'd0, busy},   32'd0);

    // Back-to-back: A5 then 3C, second word lands in hold.
    cycle(1'b0, 1'b1, 8'hA5);
    clear_caps();
    cycle(1'b0, 1'b1, 8'h3C);
    repeat (15) cycle(1'b0, 1'b0, 8'h00);
    check("b2b_bits",  {16'd0, cap[15:0]}, 32'hA53C);
    check("b2b_done",  done_cnt, 32'd2);
    check("b2b_hold",  {31'd0, ready_low_cnt > 0}, 32'd1);
    repeat (2) cycle(1'b0, 1'b0, 8'h00);

    // Bypass: second word offered exactly on the final-bit edge of the first.
    cycle(1'b0, 1'b1, 8'h0F);
    clear_caps();
    repeat (7) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'hC3);
    repeat (8) cycle(1'b0, 1'b0, 8'h00);
    check("bypass_bits", {16'd0, cap[15:0]}, 32'h0FC3);
    check("bypass_done", done_cnt, 32'd2);
    check("bypass_hold_empty", ready_low_cnt, 32'd0);
    repeat (2) cycle(1'b0, 1'b0, 8'h00);

    // Word 0x01: LSB-first instance sends the 1 first.
    cycle(1'b0, 1'b1, 8'h01);
    clear_caps();
    repeat (8) cycle(1'b0, 1'b0, 8'h00);
    check("lsb01_bits", {24'd0, cap_lsb[7:0]}, 32'h80);
    check("msb01_bits", {24'd0, cap[7:0]},     32'h01);
    repeat (2) cycle(1'b0, 1'b0, 8'h00);

    // Reset mid-word: 0xFF shifting, 0x55 in hold, rst on the edge ending bit 4.
    cycle(1'b0, 1'b1, 8'hFF);
    cycle(1'b0, 1'b1, 8'h55);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    clear_caps();
    repeat (12) cycle(1'b0, 1'b0, 8'h00);
    check("rstmid_out",   cap, 32'd0);
    check("rstmid_done",  done_cnt, 32'd0);
    check("rstmid_ready", ready_low_cnt, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), W'($urandom));
    end
    repeat (20) cycle(1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial front end that feeds the lab 4 sequence detector's 1-bit `in` port.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk on `out`.
- A one-entry hold register lets back-to-back words stream with no idle gap, so detector patterns that straddle word boundaries are preserved.
- Drives IDLE_BIT when no word is in flight.

Parameters:
WIDTH, 8, bits per word; legal range WIDTH >= 2
MSB_FIRST, 1, 1 = data_in[WIDTH-1] is sent first; 0 = data_in[0] is sent first
IDLE_BIT, 0, level driven on out while idle and after reset

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
data_in  input  WIDTH  parallel word to serialize
load_valid  input  1  data_in is valid this cycle
load_ready  output  1  block can accept a word this cycle
out  output  1  registered serial bit stream; connects to seqDetector `in`
busy  output  1  high while a word is being shifted (state SHIFT)
word_done  output  1  one-cycle pulse, high while the last bit of a word is on out

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). rst sampled high at a posedge clears everything; rst has priority over every other event.
- Reset values: out=IDLE_BIT, busy=0, word_done=0, load_ready=1, hold empty, bit counter=0, state=IDLE.
- Transfer: occurs at a posedge with load_valid && load_ready. load_ready = !hold_full and is derived from registered state only; it has no combinational path from load_valid.
- States: IDLE and SHIFT. busy = (state == SHIFT).
- IDLE, transfer at edge k:
  - out <= first bit, state <= SHIFT, counter <= 0, remaining bits go to the shifter.
  - The first bit is visible in the cycle after edge k.
- IDLE, no transfer: out holds IDLE_BIT.
- SHIFT: each bit is held on out for exactly one cycle. At each edge, counter increments and out <= next bit.
- word_done = (state == SHIFT && counter == WIDTH-1). It is a registered decode that coincides with the last bit.
- SHIFT, transfer at any edge: the word is written to hold and load_ready drops the next cycle.
- Edge that ends the last bit (counter == WIDTH-1), in priority order:
  - Hold full: the hold word moves to the shifter, out <= its first bit, counter <= 0, hold empties. There is no gap.
  - Else, transfer on the same edge: the word bypasses hold into the shifter, with the same timing.
  - Else: state <= IDLE, out <= IDLE_BIT.
- Hold full at the final edge: no transfer is possible because load_ready=0, so there is no three-word conflict.
- Throughput: with load_valid held high and data available, exactly WIDTH*N contiguous bits for N words, with no IDLE_BIT inserted.
- load_valid deasserted while load_ready=0: no effect. The word is simply not taken; data_in need not be stable.
- Reset mid-word: the shifter and hold contents are discarded. out=IDLE_BIT from the following cycle, and no word_done pulse.
- Bit order:
  - MSB_FIRST=1: data_in[WIDTH-1] down to data_in[0].
  - MSB_FIRST=0: data_in[0] up to data_in[WIDTH-1].

Test Plan:
- Reset: hold rst=1 for 2 edges with load_valid=1 -> out=IDLE_BIT(0), busy=0, word_done=0, load_ready=1, and no word accepted.
- Single word, WIDTH=8, MSB_FIRST=1, data_in=8'b0101_0011 accepted at edge k -> out = 0,1,0,1,0,0,1,1 in cycles k+1..k+8, word_done high only in cycle k+8, then out=0 and busy=0 from cycle k+9.
- Back-to-back: words 8'hA5 then 8'h3C with load_valid held -> 16 contiguous bits 10100101_00111100; load_ready=0 while hold is full; word_done pulses at bits 8 and 16; no idle bit between words.
- Bypass: second word presented exactly on the final-bit edge of the first, with hold empty -> next bit is its first bit, no gap, and hold stays empty.
- LSB_FIRST (MSB_FIRST=0), data_in=8'h01 -> out = 1,0,0,0,0,0,0,0.
- Reset mid-word: rst=1 at bit 4 of 8'hFF with 8'h55 in hold -> out=0 from the next cycle, load_ready=1, no word_done pulse, and neither word resumes after rst drops.
